// File: rtl/dshot_frame_rx.sv
// dshot_frame_rx: DShot bit receiver; classifies pulses by high time, assembles 16-bit frames, checks CRC.
// Ports: clk/rst_n (async active-low); dshotPin raw line in; frameData/throttle/telem/outputSpeed hold
// the last CRC-valid frame; frameValid/crcErr/bitErr are mutually exclusive one-cycle pulses.
module dshot_frame_rx #(
  parameter int CLK_HZ = 16000000,
  parameter int BAUD   = 150000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dshotPin,
  output logic [15:0] frameData,
  output logic [10:0] throttle,
  output logic        telem,
  output logic [7:0]  outputSpeed,
  output logic        frameValid,
  output logic        crcErr,
  output logic        bitErr
);
  localparam int BC = CLK_HZ / BAUD;
  localparam logic [15:0] BIT_CYC  = 16'(BC);
  localparam logic [15:0] THRESH   = 16'(BC * 9 / 16);
  localparam logic [15:0] MIN_HIGH = 16'(BC / 8);
  localparam logic [15:0] TIMEOUT  = 16'(2 * BC);
  typedef enum logic [1:0] {IDLE, HIGH, LOW, CHECK} state_t;
  state_t state, state_d;
  logic s1, s, prev, rise, fall, crc_ok;
  logic valid_d, crc_err_d, bit_err_d;
  logic [15:0] cnt, cnt_d, cnt_inc, shift, shift_d;
  logic [4:0] bit_idx, bit_idx_d;
  logic [10:0] thr, diff;
  logic [7:0] speed;
  assign rise = s & ~prev;
  assign fall = ~s & prev;
  assign cnt_inc = &cnt ? cnt : cnt + 16'd1;
  assign crc_ok = (shift[15:12] ^ shift[11:8] ^ shift[7:4]) == shift[3:0];
  assign thr = shift[15:5];
  assign diff = thr - 11'd48;
  assign speed = thr < 11'd48 ? 8'd0 : diff[10:3];
  assign throttle = frameData[15:5];
  assign telem = frameData[4];
  // The edge-detect cycle is itself the first high cycle, so cnt equals the
  // high time in cycles when the falling edge is seen.
  always_comb begin
    state_d = state;
    cnt_d = cnt_inc;
    shift_d = shift;
    bit_idx_d = bit_idx;
    valid_d = 1'b0;
    crc_err_d = 1'b0;
    bit_err_d = 1'b0;
    case (state)
      IDLE: begin
        cnt_d = rise ? 16'd1 : cnt;
        state_d = rise ? HIGH : IDLE;
      end
      HIGH: begin
        if (fall && cnt < MIN_HIGH) begin
          bit_err_d = 1'b1;
          bit_idx_d = 5'd0;
          state_d = IDLE;
        end else if (fall) begin
          shift_d = {shift[14:0], cnt >= THRESH};
          bit_idx_d = bit_idx + 5'd1;
          cnt_d = 16'd0;
          state_d = bit_idx == 5'd15 ? CHECK : LOW;
        end else if (cnt >= BIT_CYC) begin
          bit_err_d = 1'b1;
          bit_idx_d = 5'd0;
          state_d = IDLE;
        end
      end
      LOW: begin
        if (rise) begin
          cnt_d = 16'd1;
          state_d = HIGH;
        end else if (cnt >= TIMEOUT) begin
          bit_err_d = 1'b1;
          bit_idx_d = 5'd0;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = crc_ok;
        crc_err_d = ~crc_ok;
        bit_idx_d = 5'd0;
        cnt_d = s ? 16'd1 : 16'd0;
        state_d = s ? HIGH : IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s <= 1'b0;
      prev <= 1'b0;
      state <= IDLE;
      cnt <= 16'd0;
      shift <= 16'd0;
      bit_idx <= 5'd0;
      frameData <= 16'd0;
      outputSpeed <= 8'd0;
      frameValid <= 1'b0;
      crcErr <= 1'b0;
      bitErr <= 1'b0;
    end else begin
      s1 <= dshotPin;
      s <= s1;
      prev <= s;
      state <= state_d;
      cnt <= cnt_d;
      shift <= shift_d;
      bit_idx <= bit_idx_d;
      frameValid <= valid_d;
      crcErr <= crc_err_d;
      bitErr <= bit_err_d;
      if (valid_d) begin
        frameData <= shift;
        outputSpeed <= speed;
      end
    end
  end
endmodule

// File: tb/tb_dshot_frame_rx.sv
// tb_dshot_frame_rx: directed-vector bench for dshot_frame_rx at the default 16 MHz / 150 kbit.
module tb_dshot_frame_rx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pin = 1'b0;
  logic [15:0] frameData;
  logic [10:0] throttle;
  logic telem;
  logic [7:0] outputSpeed;
  logic frameValid, crcErr, bitErr;
  int n_checks = 0;
  int n_errors = 0;
  int cnt_v = 0, cnt_c = 0, cnt_b = 0, cnt_ov = 0;
  int sv, sc, sb;
  always #5 clk = ~clk;
  dshot_frame_rx dut (
    .clk(clk), .rst_n(rst_n), .dshotPin(pin), .frameData(frameData), .throttle(throttle),
    .telem(telem), .outputSpeed(outputSpeed), .frameValid(frameValid), .crcErr(crcErr), .bitErr(bitErr)
  );
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      cnt_v += int'(frameValid);
      cnt_c += int'(crcErr);
      cnt_b += int'(bitErr);
      if (int'(frameValid) + int'(crcErr) + int'(bitErr) > 1) cnt_ov++;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_bits(input logic [15:0] f, input int h1, input int h0, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      int h;
      h = f[15 - i] ? h1 : h0;
      pin = 1'b1;
      cyc(h);
      pin = 1'b0;
      cyc(106 - h);
    end
  endtask
  task automatic mark();
    sv = cnt_v;
    sc = cnt_c;
    sb = cnt_b;
  endtask
  task automatic expect_ev(input string tag, input int v, input int c, input int b);
    cyc(10);
    check({tag, " valid"}, cnt_v - sv, v);
    check({tag, " crcerr"}, cnt_c - sc, c);
    check({tag, " biterr"}, cnt_b - sb, b);
  endtask
  task automatic expect_out(input string tag, input logic [15:0] d, input logic [7:0] s);
    check({tag, " data"}, 32'(frameData), 32'(d));
    check({tag, " throttle"}, 32'(throttle), 32'(d[15:5]));
    check({tag, " telem"}, 32'(telem), 32'(d[4]));
    check({tag, " speed"}, 32'(outputSpeed), 32'(s));
  endtask
  task automatic frame(input string tag, input logic [15:0] f, input int h1, input int h0,
                       input int v, input int c, input int b, input logic [15:0] d, input logic [7:0] s);
    mark();
    send_bits(f, h1, h0, 16);
    expect_ev(tag, v, c, b);
    expect_out(tag, d, s);
  endtask
  initial begin
    cyc(5);
    expect_out("reset", 16'h0000, 8'd0);
    check("reset pulses", 32'({frameValid, crcErr, bitErr}), 32'd0);
    rst_n = 1'b1;
    cyc(5);
    frame("f830b", 16'h830B, 80, 40, 1, 0, 0, 16'h830B, 8'd125);
    frame("fffff", 16'hFFFF, 80, 40, 1, 0, 0, 16'hFFFF, 8'd249);
    check("max throttle", 32'(throttle), 32'd2047);
    frame("f0000", 16'h0000, 80, 40, 1, 0, 0, 16'h0000, 8'd0);
    frame("thr56", 16'h0707, 80, 40, 1, 0, 0, 16'h0707, 8'd1);
    frame("thr47", 16'h05EB, 80, 40, 1, 0, 0, 16'h05EB, 8'd0);
    frame("pre_bad", 16'h830B, 80, 40, 1, 0, 0, 16'h830B, 8'd125);
    frame("badcrc", 16'h830A, 80, 40, 0, 1, 0, 16'h830B, 8'd125);
    frame("hi59", 16'hFFFF, 59, 58, 1, 0, 0, 16'hFFFF, 8'd249);
    frame("hi58", 16'h830B, 58, 58, 1, 0, 0, 16'h0000, 8'd0);
    mark();
    send_bits(16'hFFFF, 80, 40, 5);
    pin = 1'b1;
    cyc(12);
    pin = 1'b0;
    cyc(40);
    expect_ev("glitch", 0, 0, 1);
    frame("after_glitch", 16'h0707, 80, 40, 1, 0, 0, 16'h0707, 8'd1);
    frame("hi13", 16'h0000, 80, 13, 1, 0, 0, 16'h0000, 8'd0);
    mark();
    send_bits(16'h830B, 80, 40, 8);
    cyc(250);
    expect_ev("timeout", 0, 0, 1);
    frame("after_timeout", 16'hFFFF, 80, 40, 1, 0, 0, 16'hFFFF, 8'd249);
    mark();
    pin = 1'b1;
    cyc(120);
    pin = 1'b0;
    cyc(40);
    expect_ev("stuck_high", 0, 0, 1);
    frame("after_stuck", 16'h05EB, 80, 40, 1, 0, 0, 16'h05EB, 8'd0);
    mark();
    send_bits(16'hFFFF, 80, 40, 9);
    pin = 1'b1;
    cyc(30);
    rst_n = 1'b0;
    pin = 1'b0;
    cyc(3);
    expect_out("in_reset", 16'h0000, 8'd0);
    check("in_reset valid", 32'(frameValid), 32'd0);
    check("partial pulses", cnt_v + cnt_c + cnt_b - sv - sc - sb, 0);
    rst_n = 1'b1;
    cyc(5);
    frame("after_reset", 16'h830B, 80, 40, 1, 0, 0, 16'h830B, 8'd125);
    check("pulse overlap", cnt_ov, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
